// File: rtl/debounce_pulse_array.sv
// Multi-channel push-button/switch debouncer with a one-shot pulse per channel.
// Each channel has a 2-flop synchroniser, a 4-state debounce FSM, a registered
// debounced level and a pulse stretcher. The pulse fires on the accepted press
// or the accepted release, selected by a parameter.
// Optional build macro DB_AUTOREPEAT_EN adds hold-to-repeat ticks while a
// channel stays in HIGH.
// Ports: CLK  - system clock
//        RST  - asynchronous active-high reset
//        BTN  - raw asynchronous inputs
//        DB_LEVEL  - debounced level per channel
//        PULSE     - stretched one-shot pulse per channel
//        ANY_PULSE - one-cycle flag on any pulse-start event
module debounce_pulse_array #(
    parameter int               N_CH           = 4,
    parameter int               CNT_W          = 16,
    parameter int               RISE_CLKS      = 100,
    parameter int               FALL_CLKS      = 100,
    parameter int               PULSE_CLKS     = 3,
    parameter int               PULSE_ON_PRESS = 0,
    parameter logic [N_CH-1:0]  INV_MASK       = '0,
    parameter int               REPEAT_DELAY   = 25000,
    parameter int               REPEAT_PERIOD  = 5000
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [N_CH-1:0] BTN,
    output logic [N_CH-1:0] DB_LEVEL,
    output logic [N_CH-1:0] PULSE,
    output logic            ANY_PULSE
);

    typedef enum logic [1:0] {
        LOW         = 2'd0,
        LOW_TO_HIGH = 2'd1,
        HIGH        = 2'd2,
        HIGH_TO_LOW = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] RISE_TERM  = CNT_W'(RISE_CLKS - 1);
    localparam logic [CNT_W-1:0] FALL_TERM  = CNT_W'(FALL_CLKS - 1);
    localparam logic [CNT_W-1:0] PULSE_TERM = CNT_W'(PULSE_CLKS - 1);

    // Reject parameter sets the counters and repeat reload cannot honour.
    if (N_CH < 1 || N_CH > 16 || RISE_CLKS < 2 || FALL_CLKS < 2 ||
        PULSE_CLKS < 1 || REPEAT_PERIOD <= PULSE_CLKS ||
        REPEAT_DELAY < REPEAT_PERIOD) begin : g_param_check
        $error("debounce_pulse_array: illegal parameter combination");
    end

    logic [N_CH-1:0] ev;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [1:0]       sync;
        logic             s;
        state_t           state, state_nxt;
        logic [CNT_W-1:0] cnt, cnt_nxt;
        logic             rise, fall, tick;
        logic             db_q, pulse_q;
        logic [CNT_W-1:0] pcnt;

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) sync <= '0;
            else     sync <= {sync[0], BTN[i] ^ INV_MASK[i]};
        end
        assign s = sync[1];

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                state <= LOW;
                cnt   <= '0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
            end
        end

        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            rise      = 1'b0;
            fall      = 1'b0;
            case (state)
                LOW: begin
                    if (s) begin
                        state_nxt = LOW_TO_HIGH;
                        cnt_nxt   = CNT_W'(1);
                    end else begin
                        cnt_nxt   = '0;
                    end
                end
                LOW_TO_HIGH: begin
                    if (!s) begin
                        state_nxt = LOW;
                        cnt_nxt   = '0;
                    end else if (cnt == RISE_TERM) begin
                        state_nxt = HIGH;
                        cnt_nxt   = '0;
                        rise      = 1'b1;
                    end else begin
                        cnt_nxt   = cnt + CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (!s) begin
                        state_nxt = HIGH_TO_LOW;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
                HIGH_TO_LOW: begin
                    if (s) begin
                        state_nxt = HIGH;
                        cnt_nxt   = '0;
                    end else if (cnt == FALL_TERM) begin
                        state_nxt = LOW;
                        cnt_nxt   = '0;
                        fall      = 1'b1;
                    end else begin
                        cnt_nxt   = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = LOW;
                    cnt_nxt   = '0;
                end
            endcase
        end

`ifdef DB_AUTOREPEAT_EN
        localparam logic [CNT_W-1:0] REP_TERM   = CNT_W'(REPEAT_DELAY - 1);
        localparam logic [CNT_W-1:0] REP_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);
        logic [CNT_W-1:0] hcnt;

        assign tick = (state == HIGH) && (hcnt == REP_TERM);

        // Held at zero outside HIGH so every entry into HIGH starts a fresh delay;
        // reloading to DELAY-PERIOD spaces later ticks by PERIOD cycles.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST)                 hcnt <= '0;
            else if (state != HIGH)  hcnt <= '0;
            else if (tick)           hcnt <= REP_RELOAD;
            else                     hcnt <= hcnt + CNT_W'(1);
        end
`else
        assign tick = 1'b0;
`endif

        assign ev[i] = ((PULSE_ON_PRESS != 0) ? rise : fall) | tick;

        always_ff @(posedge CLK or posedge RST) begin
            if (RST)       db_q <= 1'b0;
            else if (rise) db_q <= 1'b1;
            else if (fall) db_q <= 1'b0;
        end

        // A new event reloads the count, so overlapping events extend the pulse.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                pulse_q <= 1'b0;
                pcnt    <= '0;
            end else if (ev[i]) begin
                pulse_q <= 1'b1;
                pcnt    <= PULSE_TERM;
            end else if (pcnt != '0) begin
                pcnt    <= pcnt - CNT_W'(1);
            end else begin
                pulse_q <= 1'b0;
            end
        end

        assign DB_LEVEL[i] = db_q;
        assign PULSE[i]    = pulse_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) ANY_PULSE <= 1'b0;
        else     ANY_PULSE <= |ev;
    end

endmodule

// File: doc/debounce_pulse_array.md
# debounce_pulse_array

Parametrised multi-channel debouncer with per-channel one-shot pulse generation for raw push-button and switch inputs on the Basys3 RAT system. Each channel has its own 2-flop synchroniser, debounce FSM, debounced-level output and pulse stretcher. The pulse edge is selectable (press or release), and optional hold-to-repeat can be compiled in. The block sits between the board I/O pins and the RAT interrupt and input-port logic, and replaces per-button single-channel instances.

## Interface
- N_CH, 4, number of independent channels (1..16)
- CNT_W, 16, width of each per-channel counter; must hold every count parameter below
- RISE_CLKS, 100, consecutive synchronised-high samples required to accept a press (≥2)
- FALL_CLKS, 100, consecutive synchronised-low samples required to accept a release (≥2)
- PULSE_CLKS, 3, PULSE width in cycles (≥1)
- PULSE_ON_PRESS, 0, 1: pulse on accepted press; 0: pulse on accepted release
- INV_MASK, '0, N_CH-bit mask; a set bit marks an active-low input, which is inverted before synchronisation
- REPEAT_DELAY, 25000, cycles in HIGH before the first repeat pulse (used only with DB_AUTOREPEAT_EN)
- REPEAT_PERIOD, 5000, cycles between subsequent repeat pulses (> PULSE_CLKS)
- CLK  in  1  system clock, 50 MHz RAT clock
- RST  in  1  asynchronous, active-high reset
- BTN  in  N_CH  raw asynchronous inputs
- DB_LEVEL  out  N_CH  debounced level per channel (registered)
- PULSE  out  N_CH  one-shot pulse per channel (registered)
- ANY_PULSE  out  1  registered OR of the per-channel pulse-start events

## Operation
- Per channel: b = BTN[i] ^ INV_MASK[i] feeds a 2-flop synchroniser. Its output s is the only signal the FSM samples.
- FSM states: LOW, LOW_TO_HIGH, HIGH, HIGH_TO_LOW. Reset state is LOW with cnt = 0.
- LOW: s = 1 → LOW_TO_HIGH, cnt ← 1. Otherwise stay, cnt ← 0.
- LOW_TO_HIGH:
  - s = 0 → LOW, cnt ← 0.
  - s = 1 and cnt = RISE_CLKS-1 → HIGH, cnt ← 0, DB_LEVEL ← 1.
  - Otherwise cnt++.
- HIGH: s = 0 → HIGH_TO_LOW, cnt ← 1. Otherwise stay.
- HIGH_TO_LOW:
  - s = 1 → HIGH, cnt ← 0.
  - s = 0 and cnt = FALL_CLKS-1 → LOW, cnt ← 0, DB_LEVEL ← 0.
  - Otherwise cnt++.
- Pulse event:
  - PULSE_ON_PRESS = 1: the LOW_TO_HIGH→HIGH transition.
  - PULSE_ON_PRESS = 0: the HIGH_TO_LOW→LOW transition.
  - With DB_AUTOREPEAT_EN: also each repeat tick.
- Pulse stretcher: on an event, PULSE[i] ← 1 and pcnt ← PULSE_CLKS-1. While pcnt ≠ 0, pcnt--. PULSE[i] drops on the edge after pcnt reaches 0.
  - An event arriving while PULSE[i] is high restarts pcnt, extending the pulse rather than ignoring the event.
- Channels are fully independent. Simultaneous events on several channels each produce their own PULSE bit.
- ANY_PULSE is high for exactly one cycle, on the edge where any channel's pulse starts.

## Timing
- Reset values: DB_LEVEL = 0, PULSE = 0, ANY_PULSE = 0, all FSMs LOW, all counters 0, synchroniser flops 0.
- An asserted RST mid-count or mid-pulse clears everything immediately. After release, a held input is re-debounced from LOW.
- Let t0 be the first edge that samples a stable b = 1:
  - DB_LEVEL rises at edge t0+RISE_CLKS+1.
  - In press mode, PULSE rises on the same edge and stays high for PULSE_CLKS cycles.
- Release is symmetric: DB_LEVEL falls FALL_CLKS+1 edges after the first edge sampling b = 0.
- Any glitch shorter than RISE_CLKS (or FALL_CLKS) synchronised samples produces no DB_LEVEL change and no pulse. The counter restarts on the next opposite transition.
- No counter wraps: counts stop at the terminal value by construction.

## Configuration
- DB_AUTOREPEAT_EN defined:
  - Each channel adds a hold counter, cleared on entry to HIGH and incrementing while in HIGH.
  - A repeat tick occurs when the counter reaches REPEAT_DELAY-1. The counter then reloads so that later ticks occur every REPEAT_PERIOD cycles.
  - Ticks stop on leaving HIGH, and occur in both press and release modes.
- Undefined: no hold counter is synthesised; REPEAT_* are ignored; exactly one event per press/release cycle.

## Test plan
- Clean press, press mode (N_CH=4, RISE=FALL=4, PULSE_CLKS=3): BTN[0] 0→1 held for 20 cycles → DB_LEVEL[0] rises 5 edges after first sample, PULSE[0] high 3 cycles, ANY_PULSE high 1 cycle, other channels stay 0.
- Bounce rejection: BTN[1] toggles 1,0,1,0 each for 2 cycles, then stays 1 → exactly one DB_LEVEL[1] rise, 5 edges after the final stable rise; exactly one pulse.
- Release mode (PULSE_ON_PRESS=0) with INV_MASK[2]=1: BTN[2] held 0 for 10 cycles, then 1 → no pulse on press; one 3-cycle PULSE[2] starting 5 edges after the release is first sampled.
- Simultaneous events: BTN[0] and BTN[3] rise on the same cycle → both PULSE bits rise on the same edge, ANY_PULSE high 1 cycle.
- Reset mid-debounce: assert RST after 2 of 4 high samples, release with BTN still high → all outputs 0 during reset; DB_LEVEL rises RISE_CLKS+1 edges after the first post-reset sample.
- With DB_AUTOREPEAT_EN (REPEAT_DELAY=10, REPEAT_PERIOD=6): hold BTN[0] for 40 cycles → initial pulse, then pulses at 10, 16, 22, 28, 34 cycles after DB_LEVEL rise; none after release.
